baud_cfg_ctrl: RTL and testbench

Baud-rate configuration controller for the serial link. Accepts speed-change requests from two requesters (A: Nios-side register write, B: local board switches), arbitrates, waits until the link is quiet, then drives the `pulse`/`speed` configuration inputs of the baud clock divider and acknowledges the winning requester once the new rate is in effect. Sits between the requesters and the divider, and tracks the currently applied speed code.

---
 rtl/baud_cfg_ctrl.sv | 172 +++++++++++++++++
 tb/tb_baud_cfg_ctrl.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/baud_cfg_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : baud_cfg_ctrl
//  Purpose  : Baud-rate configuration controller. Arbitrates speed-change
//             requests from two requesters (round-robin), waits for a quiet
//             link, strobes the baud divider, lets it settle, then acks the
//             winning requester and tracks the speed code in effect.
//  Options  : BAUD_CFG_TIMEOUT_EN - abandon a request if the link stays busy
//             for TIMEOUT_CYCLES cycles and raise sticky err_timeout.
//  Revision : 1.0 - initial release
// ============================================================================
module baud_cfg_ctrl #(
    parameter int SETTLE_CYCLES  = 3,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       clk_in,
    input  logic       rst,
    input  logic       req_a,
    input  logic       req_b,
    input  logic [1:0] speed_a,
    input  logic [1:0] speed_b,
    input  logic       tx_busy,
    input  logic       rx_busy,
    output logic       ack_a,
    output logic       ack_b,
    output logic       div_pulse,
    output logic [1:0] div_speed,
    output logic [1:0] cur_speed,
    output logic       busy,
    output logic       err_timeout
);

    localparam int                c_CNT_W       = $clog2(SETTLE_CYCLES + 1);
    localparam logic [c_CNT_W-1:0] c_SETTLE_LOAD = c_CNT_W'(SETTLE_CYCLES - 1);

    // Parameter ranges the counters can represent.
    if ((SETTLE_CYCLES < 1) || (TIMEOUT_CYCLES < 1) || (TIMEOUT_CYCLES > 65536)) begin : g_bad_cfg
        $error("baud_cfg_ctrl: SETTLE_CYCLES must be >= 1 and TIMEOUT_CYCLES in 1..65536");
    end

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_WAIT_LINK = 3'd1,
        ST_APPLY     = 3'd2,
        ST_SETTLE    = 3'd3,
        ST_ACK       = 3'd4
    } state_t;

    state_t             r_state;
    logic               r_own_b;       // current owner: 1 = requester B
    logic               r_last_b;      // last granted requester: 1 = B
    logic [1:0]         r_pend_speed;
    logic [c_CNT_W-1:0] r_settle_cnt;
    logic               r_div_pulse;
    logic [1:0]         r_div_speed;
    logic [1:0]         r_cur_speed;
    logic               r_ack_a;
    logic               r_ack_b;
    logic               r_busy;

`ifdef BAUD_CFG_TIMEOUT_EN
    localparam logic [15:0] c_TO_LAST = 16'(TIMEOUT_CYCLES - 1);
    logic [15:0] r_to_cnt;
    logic        r_err;
`endif

    // A requester whose ack is on the wire this cycle may still hold its
    // level request; mask it so it is not granted a second time.
    logic w_req_a;
    logic w_req_b;
    logic w_grant_b;
    logic w_link_idle;

    assign w_req_a     = req_a & ~r_ack_a;
    assign w_req_b     = req_b & ~r_ack_b;
    assign w_grant_b   = w_req_b & (~w_req_a | ~r_last_b);
    assign w_link_idle = ~tx_busy & ~rx_busy;

    // Control FSM with all outputs registered.
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_own_b      <= 1'b0;
            r_last_b     <= 1'b1;          // A wins the first contention
            r_pend_speed <= 2'b00;
            r_settle_cnt <= '0;
            r_div_pulse  <= 1'b0;
            r_div_speed  <= 2'b00;
            r_cur_speed  <= 2'b00;
            r_ack_a      <= 1'b0;
            r_ack_b      <= 1'b0;
            r_busy       <= 1'b0;
`ifdef BAUD_CFG_TIMEOUT_EN
            r_to_cnt     <= 16'd0;
            r_err        <= 1'b0;
`endif
        end else begin
            r_div_pulse <= 1'b0;
            r_ack_a     <= 1'b0;
            r_ack_b     <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_req_a || w_req_b) begin
                        r_own_b      <= w_grant_b;
                        r_pend_speed <= w_grant_b ? speed_b : speed_a;
                        r_div_speed  <= w_grant_b ? speed_b : speed_a;
                        r_state      <= ST_WAIT_LINK;
                        r_busy       <= 1'b1;
`ifdef BAUD_CFG_TIMEOUT_EN
                        r_to_cnt     <= 16'd0;
`endif
                    end
                end
                ST_WAIT_LINK: begin
                    if (w_link_idle) begin
                        r_state <= (r_pend_speed != r_cur_speed) ? ST_APPLY : ST_ACK;
                    end
`ifdef BAUD_CFG_TIMEOUT_EN
                    else if (r_to_cnt == c_TO_LAST) begin
                        r_state <= ST_ACK;
                        r_err   <= 1'b1;
                    end else begin
                        r_to_cnt <= r_to_cnt + 16'd1;
                    end
`endif
                end
                ST_APPLY: begin
                    r_div_pulse  <= 1'b1;
                    r_settle_cnt <= c_SETTLE_LOAD;
                    r_state      <= ST_SETTLE;
`ifdef BAUD_CFG_TIMEOUT_EN
                    r_err        <= 1'b0;
`endif
                end
                ST_SETTLE: begin
                    if (r_settle_cnt == '0) begin
                        r_cur_speed <= r_pend_speed;
                        r_state     <= ST_ACK;
                    end else begin
                        r_settle_cnt <= r_settle_cnt - c_CNT_W'(1);
                    end
                end
                ST_ACK: begin
                    r_ack_a  <= ~r_own_b;
                    r_ack_b  <= r_own_b;
                    r_last_b <= r_own_b;
                    r_state  <= ST_IDLE;
                    r_busy   <= 1'b0;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign ack_a     = r_ack_a;
    assign ack_b     = r_ack_b;
    assign div_pulse = r_div_pulse;
    assign div_speed = r_div_speed;
    assign cur_speed = r_cur_speed;
    assign busy      = r_busy;

`ifdef BAUD_CFG_TIMEOUT_EN
    assign err_timeout = r_err;
`else
    assign err_timeout = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_baud_cfg_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_baud_cfg_ctrl
//  Purpose  : Directed self-checking bench for baud_cfg_ctrl.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_baud_cfg_ctrl;

    logic       clk_in = 1'b0;
    logic       rst = 1'b1;
    logic       req_a = 1'b0;
    logic       req_b = 1'b0;
    logic [1:0] speed_a = 2'b00;
    logic [1:0] speed_b = 2'b00;
    logic       tx_busy = 1'b0;
    logic       rx_busy = 1'b0;
    logic       ack_a;
    logic       ack_b;
    logic       div_pulse;
    logic [1:0] div_speed;
    logic [1:0] cur_speed;
    logic       busy;
    logic       err_timeout;

    int checks = 0;
    int errors = 0;
    int pulse_cnt = 0;

    baud_cfg_ctrl #(
        .SETTLE_CYCLES  (3),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .clk_in      (clk_in),
        .rst         (rst),
        .req_a       (req_a),
        .req_b       (req_b),
        .speed_a     (speed_a),
        .speed_b     (speed_b),
        .tx_busy     (tx_busy),
        .rx_busy     (rx_busy),
        .ack_a       (ack_a),
        .ack_b       (ack_b),
        .div_pulse   (div_pulse),
        .div_speed   (div_speed),
        .cur_speed   (cur_speed),
        .busy        (busy),
        .err_timeout (err_timeout)
    );

    always #5 clk_in = ~clk_in;

    // Count divider strobes seen at clock edges.
    always @(posedge clk_in) begin
        if (div_pulse === 1'b1) pulse_cnt <= pulse_cnt + 1;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Step until either ack is seen or the budget runs out; n = edges taken.
    task automatic wait_ack(input int budget, output int n, output logic got_a, output logic got_b);
        n = 0;
        do begin
            step();
            n++;
        end while (!(ack_a === 1'b1 || ack_b === 1'b1) && n < budget);
        got_a = ack_a;
        got_b = ack_b;
    endtask

    initial begin
        int   n;
        int   p0;
        int   seen;
        logic ga;
        logic gb;

        // ---- reset values ----
        step();
        step();
        rst = 1'b0;
        chk("rst_cur_speed", 32'(cur_speed), 32'h0);
        chk("rst_div_speed", 32'(div_speed), 32'h0);
        chk("rst_div_pulse", 32'(div_pulse), 32'h0);
        chk("rst_acks", {30'd0, ack_a, ack_b}, 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_err", 32'(err_timeout), 32'h0);

        // ---- B requests the speed already in effect: ack, no strobe ----
        p0 = pulse_cnt;
        req_b = 1'b1; speed_b = 2'b00;
        step();                                   // edge 0
        chk("same_busy_e0", 32'(busy), 32'h1);
        step();                                   // edge 1
        chk("same_ackb_e1", 32'(ack_b), 32'h0);
        step();                                   // edge 2
        chk("same_ackb_e2", 32'(ack_b), 32'h1);
        req_b = 1'b0;
        step();                                   // edge 3
        chk("same_ackb_e3", 32'(ack_b), 32'h0);
        chk("same_busy_e3", 32'(busy), 32'h0);
        chk("same_no_pulse", 32'(pulse_cnt - p0), 32'h0);

        // ---- A requests 10 on an idle link ----
        p0 = pulse_cnt;
        req_a = 1'b1; speed_a = 2'b10;
        step();                                   // edge 0
        chk("chg_divspd_e0", 32'(div_speed), 32'h2);
        step();                                   // edge 1
        chk("chg_pulse_e1", 32'(div_pulse), 32'h0);
        step();                                   // edge 2
        chk("chg_pulse_e2", 32'(div_pulse), 32'h1);
        chk("chg_divspd_e2", 32'(div_speed), 32'h2);
        step();                                   // edge 3
        chk("chg_pulse_e3", 32'(div_pulse), 32'h0);
        step();                                   // edge 4
        chk("chg_cur_e4", 32'(cur_speed), 32'h0);
        step();                                   // edge 5
        chk("chg_cur_e5", 32'(cur_speed), 32'h2);
        chk("chg_acka_e5", 32'(ack_a), 32'h0);
        step();                                   // edge 6
        chk("chg_acka_e6", 32'(ack_a), 32'h1);
        chk("chg_ackb_e6", 32'(ack_b), 32'h0);
        req_a = 1'b0;
        step();                                   // edge 7
        chk("chg_acka_e7", 32'(ack_a), 32'h0);
        chk("chg_busy_e7", 32'(busy), 32'h0);
        chk("chg_one_pulse", 32'(pulse_cnt - p0), 32'h1);

        // ---- tx_busy holds the change off for 20 cycles ----
        tx_busy = 1'b1;
        req_b = 1'b1; speed_b = 2'b01;
        step();                                   // grant
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (div_pulse === 1'b1) seen++;
        end
        chk("txb_no_pulse_while_busy", 32'(seen), 32'h0);
        tx_busy = 1'b0;
        step();
        chk("txb_pulse_fall_edge", 32'(div_pulse), 32'h0);
        step();
        chk("txb_pulse_after_fall", 32'(div_pulse), 32'h1);
        wait_ack(10, n, ga, gb);
        chk("txb_ack_delay", 32'(n), 32'h4);
        chk("txb_ack_owner", {30'd0, ga, gb}, 32'h1);
        req_b = 1'b0;
        chk("txb_cur", 32'(cur_speed), 32'h1);

        // ---- reset during SETTLE ----
        req_a = 1'b1; speed_a = 2'b11;
        step(); step();
        step();
        chk("rstmid_pulse_e2", 32'(div_pulse), 32'h1);
        step();                                   // in SETTLE
        rst = 1'b1;
        #1;
        chk("rstmid_busy", 32'(busy), 32'h0);
        chk("rstmid_pulse", 32'(div_pulse), 32'h0);
        chk("rstmid_cur", 32'(cur_speed), 32'h0);
        chk("rstmid_divspd", 32'(div_speed), 32'h0);
        chk("rstmid_acks", {30'd0, ack_a, ack_b}, 32'h0);
        req_a = 1'b0;
        step();
        rst = 1'b0;
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (ack_a === 1'b1 || ack_b === 1'b1 || busy === 1'b1) seen++;
        end
        chk("rstmid_no_ack_after", 32'(seen), 32'h0);

        // ---- contention from cold reset: A first, then B ----
        req_a = 1'b1; speed_a = 2'b10;
        req_b = 1'b1; speed_b = 2'b01;
        wait_ack(20, n, ga, gb);
        chk("rr1_delay", 32'(n), 32'h7);
        chk("rr1_owner", {30'd0, ga, gb}, 32'h2);
        chk("rr1_cur", 32'(cur_speed), 32'h2);
        req_a = 1'b0;
        wait_ack(20, n, ga, gb);
        chk("rr1b_delay", 32'(n), 32'h7);
        chk("rr1b_owner", {30'd0, ga, gb}, 32'h1);
        chk("rr1b_cur", 32'(cur_speed), 32'h1);
        req_b = 1'b0;
        step();

        // Both again after B was served: A wins.
        req_a = 1'b1; speed_a = 2'b01;
        req_b = 1'b1; speed_b = 2'b01;
        wait_ack(20, n, ga, gb);
        chk("rr2_delay", 32'(n), 32'h3);
        chk("rr2_owner", {30'd0, ga, gb}, 32'h2);
        req_a = 1'b0; req_b = 1'b0;
        step();

        // Both again after A was served: B wins.
        req_a = 1'b1;
        req_b = 1'b1;
        wait_ack(20, n, ga, gb);
        chk("rr3_delay", 32'(n), 32'h3);
        chk("rr3_owner", {30'd0, ga, gb}, 32'h1);
        req_a = 1'b0; req_b = 1'b0;
        step();
        chk("rr_err_clear", 32'(err_timeout), 32'h0);

`ifdef BAUD_CFG_TIMEOUT_EN
        // ---- rx_busy stuck: abandon after 8 cycles in WAIT_LINK ----
        p0 = pulse_cnt;
        rx_busy = 1'b1;
        req_a = 1'b1; speed_a = 2'b11;
        wait_ack(40, n, ga, gb);
        chk("to_delay", 32'(n), 32'd10);
        chk("to_owner", {30'd0, ga, gb}, 32'h2);
        chk("to_err", 32'(err_timeout), 32'h1);
        chk("to_no_pulse", 32'(pulse_cnt - p0), 32'h0);
        chk("to_cur", 32'(cur_speed), 32'h1);
        req_a = 1'b0; rx_busy = 1'b0;
        step();
        chk("to_err_sticky", 32'(err_timeout), 32'h1);
        req_a = 1'b1;
        wait_ack(20, n, ga, gb);
        chk("to_retry_delay", 32'(n), 32'h7);
        chk("to_retry_err", 32'(err_timeout), 32'h0);
        chk("to_retry_cur", 32'(cur_speed), 32'h3);
        req_a = 1'b0;
        step();
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
